noc_router: RTL and testbench

//  Input-buffered, virtual-channel NoC router with credit-based flow control, one instance per network node.
//  A top-level controller steps every router in lockstep through the op sequence LoadStaging -> Phase0 -> Phase1.
//  The controller moves flits and credits between routers through flat staging buses, one slot per port.

---
 rtl/noc_pkg.sv | 34 +++
 rtl/vc_fifo.sv | 38 +++
 rtl/noc_router.sv | 136 +++++++++++++
 tb/tb_noc_router.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: router widths, op codes, staging-slot field offsets and slot helpers
package noc_pkg;
  localparam int MAXIO = 5;
  localparam int MAXVC = 2;
  localparam int VC_BITS = 1;
  localparam int PORT_BITS = 3;
  localparam int ROUTER_BITS = 4;
  localparam int PAYLOAD_BITS = 8;
  localparam int BUF_BITS = 1 + VC_BITS + ROUTER_BITS + PAYLOAD_BITS;
  localparam int FLIT_BITS = BUF_BITS - 1;
  localparam int BUF_DEPTH = 4;
  localparam int DATA_SIZE = 2 + VC_BITS + ROUTER_BITS + PAYLOAD_BITS;
  localparam int IN_CYCLE_SIZE = 16;
  localparam int OP_SIZE = 2;
  localparam int VALID_BIT = BUF_BITS - 1;
  localparam int VC_LSB = ROUTER_BITS + PAYLOAD_BITS;
  localparam int NREQ = MAXIO * MAXVC;
  localparam int IDX_BITS = $clog2(NREQ);
  localparam int CR_BITS = $clog2(BUF_DEPTH + 1);
  typedef enum logic [OP_SIZE-1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_PH0  = 2'd2,
    OP_PH1  = 2'd3
  } op_e;
  typedef struct packed {
    logic [VC_BITS-1:0] vc;
    logic [ROUTER_BITS-1:0] dest;
    logic [PAYLOAD_BITS-1:0] payload;
  } flit_t;
  function automatic logic [BUF_BITS-1:0] credit_slot(input logic [VC_BITS-1:0] vc);
    return {1'b1, {(BUF_BITS-1-VC_BITS){1'b0}}, vc};
  endfunction
endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: DEPTH-entry FIFO for one (port, vc); push_i/data_i write, pop_i/data_o head, full_o/empty_o status
module vc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign data_o = mem_q[rd_q];
  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(do_pop);
      wr_q <= wr_q + AW'(do_push);
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/noc_router.sv
// noc_router: VC router; op/staging buses/data in, out_staging/out_cr_staging/done/can_inject out
module noc_router
  import noc_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [OP_SIZE-1:0]        op,
  input  logic [MAXIO*BUF_BITS-1:0] in_staging,
  input  logic [MAXIO*BUF_BITS-1:0] in_cr_staging,
  input  logic [DATA_SIZE-1:0]      data,
  input  logic [IN_CYCLE_SIZE-1:0]  in_cycle,
  output logic [MAXIO*BUF_BITS-1:0] out_staging,
  output logic [MAXIO*BUF_BITS-1:0] out_cr_staging,
  output logic                      done,
  output logic [MAXVC-1:0]          can_inject
);
  logic [NREQ-1:0] push, pop, full, empty, ovf;
  flit_t head [NREQ];
  logic [PORT_BITS-1:0] table_q [2**ROUTER_BITS];
  logic [PORT_BITS-1:0] table_d [2**ROUTER_BITS];
  logic [CR_BITS-1:0] credit_q [MAXIO][MAXVC];
  logic [CR_BITS-1:0] credit_d [MAXIO][MAXVC];
  logic [IDX_BITS-1:0] ptr_q [MAXIO];
  logic [IDX_BITS-1:0] ptr_d [MAXIO];
  logic [IDX_BITS-1:0] gidx_q [MAXIO];
  logic [IDX_BITS-1:0] gidx_d [MAXIO];
  logic [IDX_BITS-1:0] gidx_c [MAXIO];
  logic [MAXIO-1:0] gnt_q, gnt_d, gnt_c;
  logic [MAXIO*BUF_BITS-1:0] out_q, out_d, cr_q, cr_d;
  logic data_flit, unused_ok;
  assign data_flit = op == OP_LOAD && data[DATA_SIZE-1] && !data[DATA_SIZE-2];
  assign unused_ok = ^{in_cycle, in_staging[BUF_BITS-1:0], in_cr_staging};
  for (genvar k = 0; k < NREQ; k++) begin : g_fifo
    localparam int I = k / MAXVC;
    localparam logic [VC_BITS-1:0] V = VC_BITS'(k % MAXVC);
    logic [FLIT_BITS-1:0] wr_data;
    logic wr;
    if (I == 0) begin : g_local
      assign wr_data = data[FLIT_BITS-1:0];
      assign wr = data_flit && data[VC_LSB +: VC_BITS] == V;
      assign ovf[k] = 1'b0;
    end else begin : g_net
      assign wr_data = in_staging[I*BUF_BITS +: FLIT_BITS];
      assign wr = op == OP_LOAD && in_staging[I*BUF_BITS+VALID_BIT] && in_staging[I*BUF_BITS+VC_LSB +: VC_BITS] == V;
      assign ovf[k] = wr && full[k];
    end
    assign push[k] = wr && !full[k];
    vc_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(FLIT_BITS)) u_fifo (
      .clk_i(clk), .rst_i(reset), .push_i(push[k]), .pop_i(pop[k]),
      .data_i(wr_data), .data_o(head[k]), .full_o(full[k]), .empty_o(empty[k])
    );
  end
  // Outputs are served in index order; an input port already matched to a lower output is skipped.
  always_comb begin
    logic [MAXIO-1:0] taken;
    int k;
    taken = '0;
    k = 0;
    gnt_c = '0;
    gidx_c = '{default: '0};
    for (int p = 0; p < MAXIO; p++)
      for (int n = 0; n < NREQ; n++) begin
        k = (int'(ptr_q[p]) + n) % NREQ;
        if (!gnt_c[p] && !empty[k] && int'(table_q[head[k].dest]) == p &&
            (p == 0 || credit_q[p][k % MAXVC] != '0) && !taken[k / MAXVC]) begin
          gnt_c[p] = 1'b1;
          gidx_c[p] = IDX_BITS'(k);
          taken[k / MAXVC] = 1'b1;
        end
      end
  end
  always_comb begin
    pop = '0;
    for (int p = 0; p < MAXIO; p++)
      for (int k = 0; k < NREQ; k++)
        if (op == OP_PH1 && gnt_q[p] && gidx_q[p] == IDX_BITS'(k)) pop[k] = 1'b1;
  end
  always_comb begin
    table_d = table_q;
    credit_d = credit_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    gidx_d = gidx_q;
    out_d = out_q;
    cr_d = cr_q;
    if (op == OP_LOAD) begin
      if (data[DATA_SIZE-1] && data[DATA_SIZE-2]) table_d[data[PAYLOAD_BITS +: ROUTER_BITS]] = data[PORT_BITS-1:0];
      for (int j = 0; j < MAXIO; j++)
        if (in_cr_staging[j*BUF_BITS+VALID_BIT] && credit_q[j][in_cr_staging[j*BUF_BITS +: VC_BITS]] != CR_BITS'(BUF_DEPTH))
          credit_d[j][in_cr_staging[j*BUF_BITS +: VC_BITS]] = credit_q[j][in_cr_staging[j*BUF_BITS +: VC_BITS]] + 1'b1;
    end
    if (op == OP_PH0) begin
      gnt_d = gnt_c;
      gidx_d = gidx_c;
      for (int p = 0; p < MAXIO; p++)
        if (gnt_c[p]) ptr_d[p] = gidx_c[p] == IDX_BITS'(NREQ-1) ? '0 : gidx_c[p] + 1'b1;
    end
    if (op == OP_PH1) begin
      out_d = '0;
      cr_d = '0;
      gnt_d = '0;
      for (int p = 0; p < MAXIO; p++)
        if (gnt_q[p]) begin
          out_d[p*BUF_BITS +: BUF_BITS] = {1'b1, head[gidx_q[p]]};
          if (p > 0) credit_d[p][head[gidx_q[p]].vc] = credit_q[p][head[gidx_q[p]].vc] - 1'b1;
          if (gidx_q[p] >= IDX_BITS'(MAXVC)) cr_d[(gidx_q[p] / MAXVC) * BUF_BITS +: BUF_BITS] = credit_slot(head[gidx_q[p]].vc);
        end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      table_q <= '{default: '0};
      for (int p = 0; p < MAXIO; p++)
        for (int v = 0; v < MAXVC; v++) credit_q[p][v] <= CR_BITS'(BUF_DEPTH);
      ptr_q <= '{default: '0};
      gidx_q <= '{default: '0};
      gnt_q <= '0;
      out_q <= '0;
      cr_q <= '0;
    end else begin
      table_q <= table_d;
      credit_q <= credit_d;
      ptr_q <= ptr_d;
      gidx_q <= gidx_d;
      gnt_q <= gnt_d;
      out_q <= out_d;
      cr_q <= cr_d;
    end
  end
  assign out_staging = out_q;
  assign out_cr_staging = cr_q;
  assign done = &empty;
  assign can_inject = ~full[MAXVC-1:0];
  // An upstream router pushing into a full network FIFO has broken credit flow control.
  assert property (@(posedge clk) disable iff (reset) ovf == '0);
endmodule

// File: tb/tb_noc_router.sv
// tb_noc_router: randomized and directed checks of noc_router against a queue-based reference model
module tb_noc_router;
  import noc_pkg::*;
  localparam int W = MAXIO * BUF_BITS;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [OP_SIZE-1:0] op = '0;
  logic [W-1:0] in_st = '0;
  logic [W-1:0] in_cr = '0;
  logic [DATA_SIZE-1:0] data = '0;
  logic [IN_CYCLE_SIZE-1:0] in_cycle = '0;
  logic [W-1:0] out_st, out_cr;
  logic done;
  logic [MAXVC-1:0] can_inject;
  int errors = 0;
  int checks = 0;
  logic [FLIT_BITS-1:0] fq [NREQ][$];
  int cred [MAXIO][MAXVC];
  int tbl [16];
  int ptr [MAXIO];
  int gk [MAXIO];
  logic [W-1:0] m_out, m_cr;
  always #5 clk = ~clk;
  noc_router dut (
    .clk(clk), .reset(reset), .op(op), .in_staging(in_st), .in_cr_staging(in_cr),
    .data(data), .in_cycle(in_cycle), .out_staging(out_st), .out_cr_staging(out_cr),
    .done(done), .can_inject(can_inject)
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] at(input int j, input logic [BUF_BITS-1:0] v);
    return W'(v) << (j * BUF_BITS);
  endfunction
  function automatic logic [BUF_BITS-1:0] fl(input int vc, input int dest, input int pay);
    return {1'b1, 1'(vc), 4'(dest), 8'(pay)};
  endfunction
  function automatic logic [BUF_BITS-1:0] crs(input int vc);
    return {1'b1, 12'b0, 1'(vc)};
  endfunction
  function automatic logic [DATA_SIZE-1:0] cfg(input int dest, input int port);
    return {2'b11, 1'b0, 4'(dest), 8'(port)};
  endfunction
  function automatic logic [DATA_SIZE-1:0] inj(input int vc, input int dest, input int pay);
    return {2'b10, 1'(vc), 4'(dest), 8'(pay)};
  endfunction
  task automatic m_reset();
    for (int k = 0; k < NREQ; k++) fq[k].delete();
    for (int p = 0; p < MAXIO; p++) begin
      for (int v = 0; v < MAXVC; v++) cred[p][v] = BUF_DEPTH;
      ptr[p] = 0;
      gk[p] = -1;
    end
    for (int d = 0; d < 16; d++) tbl[d] = 0;
    m_out = '0;
    m_cr = '0;
  endtask
  task automatic model(input logic [1:0] o, input logic [W-1:0] s, input logic [W-1:0] c, input logic [DATA_SIZE-1:0] d);
    bit taken [MAXIO];
    int k;
    logic [FLIT_BITS-1:0] f;
    if (o == 2'd1) begin
      for (int j = 1; j < MAXIO; j++)
        if (s[j*BUF_BITS+VALID_BIT]) begin
          k = j * MAXVC + int'(s[j*BUF_BITS+VC_LSB]);
          if (fq[k].size() < BUF_DEPTH) fq[k].push_back(s[j*BUF_BITS +: FLIT_BITS]);
        end
      for (int j = 0; j < MAXIO; j++)
        if (c[j*BUF_BITS+VALID_BIT] && cred[j][int'(c[j*BUF_BITS])] < BUF_DEPTH) cred[j][int'(c[j*BUF_BITS])]++;
      if (d[14] && d[13]) tbl[d[11:8]] = int'(d[2:0]);
      else if (d[14] && fq[int'(d[12])].size() < BUF_DEPTH) fq[int'(d[12])].push_back(d[12:0]);
    end else if (o == 2'd2) begin
      for (int i = 0; i < MAXIO; i++) taken[i] = 0;
      for (int p = 0; p < MAXIO; p++) begin
        gk[p] = -1;
        for (int n = 0; n < NREQ && gk[p] < 0; n++) begin
          k = (ptr[p] + n) % NREQ;
          if (fq[k].size() > 0 && tbl[fq[k][0][11:8]] == p && (p == 0 || cred[p][k % MAXVC] > 0) && !taken[k / MAXVC]) begin
            gk[p] = k;
            taken[k / MAXVC] = 1;
            ptr[p] = (k + 1) % NREQ;
          end
        end
      end
    end else if (o == 2'd3) begin
      m_out = '0;
      m_cr = '0;
      for (int p = 0; p < MAXIO; p++)
        if (gk[p] >= 0) begin
          k = gk[p];
          f = fq[k].pop_front();
          m_out |= at(p, {1'b1, f});
          if (p > 0) cred[p][k % MAXVC]--;
          if (k / MAXVC > 0) m_cr |= at(k / MAXVC, crs(k % MAXVC));
          gk[p] = -1;
        end
    end
  endtask
  task automatic check_all(input string tag);
    logic d;
    logic [MAXVC-1:0] ci;
    d = 1'b1;
    for (int k = 0; k < NREQ; k++) if (fq[k].size() != 0) d = 1'b0;
    for (int v = 0; v < MAXVC; v++) ci[v] = fq[v].size() < BUF_DEPTH;
    check({tag, ".out"}, out_st, m_out);
    check({tag, ".cr"}, out_cr, m_cr);
    check({tag, ".done"}, W'(done), W'(d));
    check({tag, ".inj"}, W'(can_inject), W'(ci));
  endtask
  task automatic step(input logic [1:0] o, input logic [W-1:0] s, input logic [W-1:0] c, input logic [DATA_SIZE-1:0] d, input string tag);
    op = o;
    in_st = s;
    in_cr = c;
    data = d;
    in_cycle = in_cycle + 1'b1;
    @(posedge clk);
    #1;
    model(o, s, c, d);
    op = '0;
    in_st = '0;
    in_cr = '0;
    data = '0;
    check_all(tag);
  endtask
  task automatic round(input logic [W-1:0] s, input logic [W-1:0] c, input logic [DATA_SIZE-1:0] d, input string tag);
    step(2'd1, s, c, d, tag);
    step(2'd2, '0, '0, '0, tag);
    step(2'd3, '0, '0, '0, tag);
  endtask
  task automatic do_reset(input logic [1:0] o);
    reset = 1'b1;
    op = o;
    data = inj(0, 0, 'h11);
    @(posedge clk);
    #1;
    reset = 1'b0;
    op = '0;
    data = '0;
    m_reset();
    check_all("reset");
  endtask
  initial begin
    logic [W-1:0] s, c;
    logic [DATA_SIZE-1:0] d;
    logic [1:0] o;
    int v, r;
    m_reset();
    @(posedge clk);
    #1;
    do_reset(2'd3);
    check("t1.inj", W'(can_inject), W'(2'b11));
    round('0, '0, cfg(3, 2), "t2cfg");
    round('0, '0, inj(0, 3, 'hA5), "t2");
    check("t2.slot2", W'(out_st[2*BUF_BITS +: BUF_BITS]), W'(14'h23A5));
    check("t2.done", W'(done), W'(1));
    do_reset(2'd0);
    round('0, '0, cfg(3, 2), "t3cfg");
    for (int n = 0; n < 5; n++) round('0, '0, inj(0, 3, n + 1), "t3");
    check("t3.blocked", W'(out_st[2*BUF_BITS +: BUF_BITS]), '0);
    check("t3.waiting", W'(done), '0);
    round('0, at(2, crs(0)), '0, "t3cr");
    check("t3.release", W'(out_st[2*BUF_BITS +: BUF_BITS]), W'(fl(0, 3, 5)));
    do_reset(2'd0);
    round('0, '0, cfg(7, 2), "t4cfg");
    for (int n = 0; n < 4; n++) begin
      round(at(1, fl(0, 7, n)) | at(3, fl(0, 7, 'h30 + n)), at(2, crs(0)), '0, "t4");
      check("t4.winner", W'({out_cr[1*BUF_BITS+VALID_BIT], out_cr[3*BUF_BITS+VALID_BIT]}), W'(n % 2 == 0 ? 2'b10 : 2'b01));
    end
    do_reset(2'd0);
    round(at(1, fl(1, 9, 'h5C)), '0, '0, "t5");
    check("t5.eject", W'(out_st[0 +: BUF_BITS]), W'(fl(1, 9, 'h5C)));
    check("t5.credit", W'(out_cr[BUF_BITS +: BUF_BITS]), W'(14'h2001));
    do_reset(2'd0);
    for (int n = 0; n < 4; n++) step(2'd1, '0, '0, inj(1, 4, n), "t6fill");
    check("t6.full", W'(can_inject), W'(2'b01));
    step(2'd1, '0, '0, inj(1, 4, 'hEE), "t6drop");
    check("t6.still", W'(can_inject), W'(2'b01));
    for (int n = 0; n < 4; n++) round('0, '0, '0, "t6drain");
    check("t6.dropped", W'(done), W'(1));
    do_reset(2'd0);
    for (int n = 0; n < 16; n++) step(2'd1, '0, '0, cfg(n, $urandom_range(0, 4)), "rcfg");
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset(2'd3);
      s = '0;
      c = '0;
      d = '0;
      o = 2'($urandom_range(0, 3));
      for (int j = 0; j < MAXIO; j++) begin
        v = $urandom_range(0, 1);
        if (j > 0 && $urandom_range(0, 1) == 1 && fq[j*MAXVC+v].size() < BUF_DEPTH)
          s |= at(j, fl(v, $urandom_range(0, 15), $urandom_range(0, 255)));
        if ($urandom_range(0, 2) == 0) c |= at(j, crs($urandom_range(0, 1)));
      end
      r = $urandom_range(0, 9);
      if (r == 0) d = cfg($urandom_range(0, 15), $urandom_range(0, 4));
      else if (r < 6) d = inj($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
      step(o, s, c, d, "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
